// File: rtl/fifo_uart_tx.sv
// Drains an 8-bit synchronous FIFO and serializes each popped byte as an 8N1 frame.
// All outputs are registered copies of values decoded from the next state and counters.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              re,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
    localparam logic [BW-1:0] BAUD_ZERO = BW'(0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    state_t            state_r, state_s;
    logic [DATA_W-1:0] shift_r, shift_s;
    logic [BW-1:0]     baud_r,  baud_s;
    logic [2:0]        bit_r,   bit_s;
    logic              tx_r, tx_s;
    logic              re_r, re_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;

    // Next-state, shift register and counter update.
    always_comb begin
        state_s = state_r;
        shift_s = shift_r;
        baud_s  = baud_r;
        bit_s   = bit_r;
        case (state_r)
            S_IDLE: begin
                if (en && !empty) begin
                    state_s = S_REQ;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_REQ: begin
                state_s = S_LOAD;
            end
            S_LOAD: begin
                shift_s = fifo_dout;
                baud_s  = BAUD_ZERO;
                bit_s   = 3'd0;
                state_s = S_START;
            end
            S_START: begin
                if (baud_r == BAUD_LAST) begin
                    baud_s  = BAUD_ZERO;
                    state_s = S_DATA;
                end else begin
                    baud_s  = baud_r + BAUD_ONE;
                end
            end
            S_DATA: begin
                if (baud_r == BAUD_LAST) begin
                    baud_s  = BAUD_ZERO;
                    shift_s = {1'b0, shift_r[DATA_W-1:1]};
                    bit_s   = bit_r + 3'd1;
                    if (bit_r == 3'd7) begin
                        state_s = S_STOP;
                    end else begin
                        state_s = S_DATA;
                    end
                end else begin
                    baud_s  = baud_r + BAUD_ONE;
                end
            end
            S_STOP: begin
                if (baud_r == BAUD_LAST) begin
                    baud_s  = BAUD_ZERO;
                    state_s = S_IDLE;
                end else begin
                    baud_s  = baud_r + BAUD_ONE;
                end
            end
            default: begin
                state_s = S_IDLE;
                shift_s = {DATA_W{1'b0}};
                baud_s  = BAUD_ZERO;
                bit_s   = 3'd0;
            end
        endcase
    end

    // Output decode from the values the registers will hold next cycle.
    always_comb begin
        tx_s   = 1'b1;
        re_s   = 1'b0;
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_s)
            S_START: tx_s = 1'b0;
            S_DATA:  tx_s = shift_s[0];
            default: tx_s = 1'b1;
        endcase
        re_s   = (state_s == S_REQ);
        busy_s = (state_s != S_IDLE);
        done_s = (state_s == S_STOP) && (baud_s == BAUD_LAST);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
            shift_r <= {DATA_W{1'b0}};
            baud_r  <= BAUD_ZERO;
            bit_r   <= 3'd0;
            tx_r    <= 1'b1;
            re_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            shift_r <= shift_s;
            baud_r  <= baud_s;
            bit_r   <= bit_s;
            tx_r    <= tx_s;
            re_r    <= re_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign tx   = tx_r;
    assign re   = re_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model, frame-level expectation model checked every cycle,
// and directed scenarios with literal expected waveforms.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
    localparam logic [3:0] IDLE_VEC = 4'b0100; // {re, tx, busy, done}

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b1;
    logic       empty;
    logic [7:0] fifo_dout;
    logic       re, tx, busy, done;

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0] fifo_q[$];
    logic [3:0] exp_q[$];
    logic [3:0] exp_cur = IDLE_VEC;
    bit         model_idle = 1'b1;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .empty(empty), .fifo_dout(fifo_dout),
        .re(re), .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, req, req, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        empty = 1'b0;
    endtask

    // Expected {re,tx,busy,done} for every cycle from REQ to the end of STOP.
    task automatic build_frame(input logic [7:0] b);
        logic bv;
        exp_q.push_back(4'b1110);
        exp_q.push_back(4'b0110);
        for (int j = 0; j < 10; j++) begin
            if (j == 0) bv = 1'b0;
            else if (j == 9) bv = 1'b1;
            else bv = b[j-1];
            for (int k = 0; k < CPB; k++)
                exp_q.push_back({1'b0, bv, 1'b1, (j == 9 && k == CPB - 1)});
        end
    endtask

    // FIFO: pops on re, data valid the cycle after the request.
    initial begin
        fifo_dout = 8'h00;
        empty = 1'b1;
        forever begin
            @(negedge clk);
            if (re === 1'b1) begin
                check("re_while_empty", int'(fifo_q.size() != 0), 1);
                if (fifo_q.size() != 0) fifo_dout = fifo_q.pop_front();
            end
            empty = (fifo_q.size() == 0);
        end
    end

    // Frame-level model advanced on each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            if (rst !== 1'b1) begin
                exp_q.delete();
                model_idle = 1'b1;
                exp_cur = IDLE_VEC;
            end else if (exp_q.size() != 0) begin
                exp_cur = exp_q.pop_front();
                model_idle = 1'b0;
            end else if (model_idle && en && !empty) begin
                build_frame(fifo_q[0]);
                exp_cur = exp_q.pop_front();
                model_idle = 1'b0;
            end else begin
                exp_cur = IDLE_VEC;
                model_idle = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("cycle_model", int'({re, tx, busy, done}),
                  int'((rst === 1'b1) ? exp_cur : IDLE_VEC));
        end
    end

    task automatic wait_re(input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (re === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check({tag, "_re_timeout"}, int'(found), 1);
    endtask

    // Called at the REQ negedge; checks LOAD then the 40-cycle frame.
    task automatic capture_frame(input logic [0:9] pat, input string tag);
        logic [39:0] txs;
        int dpos, dcnt, rcnt, bad;
        dpos = -1; dcnt = 0; rcnt = 0;
        @(negedge clk);
        check({tag, "_load_re"}, int'(re), 0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            txs[i] = tx;
            if (done === 1'b1) begin
                dcnt++;
                if (dpos < 0) dpos = i;
            end
            if (re === 1'b1) rcnt++;
        end
        for (int j = 0; j < 10; j++) begin
            bad = 0;
            for (int k = 0; k < CPB; k++)
                if (txs[j*CPB+k] !== pat[j]) bad++;
            check({tag, "_bit_cycles_wrong"}, bad, 0);
        end
        check({tag, "_done_count"}, dcnt, 1);
        check({tag, "_done_pos"}, dpos, 39);
        check({tag, "_re_in_frame"}, rcnt, 0);
    endtask

    initial begin
        logic [0:9] pat_a5;
        logic [0:9] pat_c3;
        logic [89:0] ctx;
        logic [89:0] cre;
        logic [89:0] cdn;
        int cnt, run;
        pat_a5 = 10'b0101001011;
        pat_c3 = 10'b0110000111;

        // Reset held with a byte available and en high.
        push_byte(8'hA5);
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", int'({re, tx, busy, done}), int'(IDLE_VEC));
        end
        #2 rst = 1'b1;

        // Single byte 0xA5.
        @(negedge clk);
        check("a5_re_latency", int'(re), 1);
        capture_frame(pat_a5, "a5");

        // Back-to-back 0x00, 0xFF.
        push_byte(8'h00);
        push_byte(8'hFF);
        wait_re("b2b");
        ctx[0] = tx; cre[0] = re; cdn[0] = done;
        for (int i = 1; i < 90; i++) begin
            @(negedge clk);
            ctx[i] = tx; cre[i] = re; cdn[i] = done;
        end
        cnt = 0;
        for (int i = 6; i < 38; i++) if (ctx[i]) cnt++;
        check("b2b_zero_data_ones", cnt, 0);
        run = 0;
        for (int i = 38; i < 90; i++) begin
            if (!ctx[i]) break;
            run++;
        end
        check("b2b_stop_plus_gap_high", run, 7);
        cnt = 0;
        for (int i = 49; i < 81; i++) if (!ctx[i]) cnt++;
        check("b2b_ff_data_zeros", cnt, 0);
        cnt = 0;
        for (int i = 0; i < 90; i++) if (cre[i]) cnt++;
        check("b2b_re_count", cnt, 2);
        check("b2b_second_re_pos", int'(cre[43]), 1);
        cnt = 0;
        for (int i = 0; i < 90; i++) if (cdn[i]) cnt++;
        check("b2b_done_count", cnt, 2);

        // Empty FIFO for 50 cycles.
        cnt = 0; run = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (re) cnt++;
            if (!tx) run++;
        end
        check("empty_re_count", cnt, 0);
        check("empty_tx_low_cycles", run, 0);

        // en low with a byte queued, then en high.
        en = 1'b0;
        push_byte(8'h3C);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (re || busy) cnt++;
        end
        check("en_low_activity", cnt, 0);
        en = 1'b1;
        @(negedge clk);
        check("en_high_re_next", int'(re), 1);
        repeat (45) @(negedge clk);

        // en dropped during DATA bit 3 with another byte queued.
        push_byte(8'h5A);
        push_byte(8'h96);
        wait_re("endrop");
        repeat (19) @(negedge clk);
        en = 1'b0;
        cnt = 0; run = 0;
        for (int i = 20; i < 100; i++) begin
            @(negedge clk);
            if (re) cnt++;
            if (done) run++;
        end
        check("endrop_extra_re", cnt, 0);
        check("endrop_done_count", run, 1);
        check("endrop_idle", int'({busy, tx}), 1);

        // Reset during DATA bit 5, then a fresh frame.
        en = 1'b1;
        wait_re("rstmid");
        repeat (27) @(negedge clk);
        #2 rst = 1'b0;
        #1 check("rstmid_tx_busy", int'({tx, busy}), 2);
        push_byte(8'hC3);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("c3_re_latency", int'(re), 1);
        capture_frame(pat_c3, "c3");
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
